// File: rtl/ysyx_23060332_pkg.sv
// +------------------------------------------------------------------+
// | ysyx_23060332_pkg : shared types/constants for the fetch memory  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package ysyx_23060332_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned CNT_W = 3;

  localparam logic [XLEN-1:0] DEFAULT_BASE = 32'h8000_0000;
  localparam logic [XLEN-1:0] EBREAK_INST = 32'h0010_0073;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } imem_state_e;

endpackage

`default_nettype wire

// File: rtl/ysyx_23060332_sram_1r1w.sv
// +------------------------------------------------------------------+
// | ysyx_23060332_sram_1r1w : word array, sync write, async read     |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module ysyx_23060332_sram_1r1w
  import ysyx_23060332_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  // Contents are intentionally not reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The reader samples this on the accept edge, so a same-edge write yields the old word.
  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/ysyx_23060332_imem.sv
// +------------------------------------------------------------------+
// | ysyx_23060332_imem : fixed-latency instruction fetch memory      |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module ysyx_23060332_imem
  import ysyx_23060332_pkg::*;
#(
  parameter int unsigned     DEPTH   = 1024,
  parameter logic [XLEN-1:0] BASE    = DEFAULT_BASE,
  parameter int unsigned     LATENCY = 2,
  localparam int unsigned    AW      = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_inst,
  output logic            resp_err,
  input  logic            ld_en,
  input  logic [AW-1:0]   ld_addr,
  input  logic [XLEN-1:0] ld_data
);

  localparam logic [XLEN:0]    LIMIT    = (XLEN + 1)'(DEPTH) << 2;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  imem_state_e      state;
  imem_state_e      state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  data_q;
  logic             err_q;

  logic [XLEN-1:0]  offset;
  logic             addr_err;
  logic             accept;
  logic [XLEN-1:0]  rd_data;

  // Addresses below BASE wrap to huge offsets and so fail the range check too.
  assign offset   = req_addr - BASE;
  assign addr_err = (req_addr[1:0] != 2'b00) || ({1'b0, offset} >= LIMIT);
  assign accept   = req_valid && (state == ST_IDLE);

  ysyx_23060332_sram_1r1w #(
    .DEPTH (DEPTH)
  ) u_sram (
    .clk   (clk),
    .we    (ld_en),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (offset[AW+1:2]),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt    <= CNT_INIT;
        data_q <= addr_err ? EBREAK_INST : rd_data;
        err_q  <= addr_err;
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = (LATENCY == 1) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_inst  = resp_valid ? data_q : '0;
  assign resp_err   = resp_valid && err_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060332_imem.sv
// Bench for ysyx_23060332_imem: three builds (LATENCY 2, 1, 7) on one clock,
// directed vector table on the LATENCY=2 build, random fetch streams on the others.
`default_nettype none

module tb_ysyx_23060332_imem;

  localparam int NI = 3;
  localparam int DEPTH = 1024;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] EBRK = 32'h0010_0073;

  logic clk = 1'b0;
  logic rst;
  logic [NI-1:0]       req_valid, req_ready, resp_valid, resp_ready, resp_err, ld_en;
  logic [NI-1:0][31:0] req_addr, resp_inst, ld_data;
  logic [NI-1:0][9:0]  ld_addr;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 7);
    ysyx_23060332_imem #(
      .DEPTH   (DEPTH),
      .BASE    (BASE),
      .LATENCY (L)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_addr   (req_addr[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_inst  (resp_inst[g]),
      .resp_err   (resp_err[g]),
      .ld_en      (ld_en[g]),
      .ld_addr    (ld_addr[g]),
      .ld_data    (ld_data[g])
    );
  end

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  exp_t        sb[$];
  logic [31:0] model [NI][DEPTH];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 7);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int k, input int idx, input logic [31:0] d);
    ld_en[k]   = 1'b1;
    ld_addr[k] = 10'(idx);
    ld_data[k] = d;
    step;
    ld_en[k]   = 1'b0;
    model[k][idx] = d;
  endtask

  // One complete fetch with resp_ready held high; optional load on the accept edge.
  task automatic fetch(input int k, input logic [31:0] addr, input logic [31:0] ei,
                       input logic ee, input bit ld, input int li,
                       input logic [31:0] ld_d, input string nm);
    int   n;
    exp_t e;
    req_valid[k]  = 1'b1;
    req_addr[k]   = addr;
    resp_ready[k] = 1'b1;
    n = 0;
    while (req_ready[k] !== 1'b1 && n < 20) begin
      step;
      n++;
    end
    chk({nm, "/ready"}, 32'(req_ready[k]), 32'd1);
    if (ld) begin
      ld_en[k]   = 1'b1;
      ld_addr[k] = 10'(li);
      ld_data[k] = ld_d;
    end
    sb.push_back('{ei, ee});
    step;
    req_valid[k] = 1'b0;
    ld_en[k]     = 1'b0;
    req_addr[k]  = ~addr;
    if (ld) model[k][li] = ld_d;
    n = 1;
    if (lat_of(k) > 1) begin
      chk({nm, "/wait_inst"}, resp_inst[k], 32'h0);
      chk({nm, "/wait_err"}, 32'(resp_err[k]), 32'd0);
    end
    while (resp_valid[k] !== 1'b1 && n < 12) begin
      step;
      n++;
    end
    chk({nm, "/lat"}, 32'(n), 32'(lat_of(k)));
    e = sb.pop_front();
    chk({nm, "/inst"}, resp_inst[k], e.inst);
    chk({nm, "/err"}, 32'(resp_err[k]), 32'(e.err));
    step;
    chk({nm, "/valid_drop"}, 32'(resp_valid[k]), 32'd0);
    chk({nm, "/ready_back"}, 32'(req_ready[k]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        vt[8];
    int          n, idx, r, li;
    bit          dold;
    logic [31:0] addr, off, ei, ldv;
    logic        ee;

    vt[0] = '{BASE,                 32'h0010_0093, 1'b0};
    vt[1] = '{BASE + 32'd2,         EBRK,          1'b1};
    vt[2] = '{BASE + 32'(4*DEPTH),  EBRK,          1'b1};
    vt[3] = '{BASE - 32'd4,         EBRK,          1'b1};
    vt[4] = '{BASE + 32'(4*1023),   32'hCAFE_F00D, 1'b0};
    vt[5] = '{BASE + 32'd1,         EBRK,          1'b1};
    vt[6] = '{BASE + 32'd20,        32'h1234_5678, 1'b0};
    vt[7] = '{32'h0000_0000,        EBRK,          1'b1};

    rst        = 1'b0;
    req_valid  = '0;
    resp_ready = '0;
    ld_en      = '0;
    req_addr   = '0;
    ld_data    = '0;
    ld_addr    = '0;
    step;
    step;
    chk("reset/req_ready", 32'(req_ready[0]), 32'd1);
    chk("reset/resp_valid", 32'(resp_valid[0]), 32'd0);
    chk("reset/resp_inst", resp_inst[0], 32'h0);
    chk("reset/resp_err", 32'(resp_err[0]), 32'd0);
    rst = 1'b1;
    step;

    load(0, 0, 32'h0010_0093);
    load(0, 1, 32'h0000_0013);
    load(0, 5, 32'h1234_5678);
    load(0, 1023, 32'hCAFE_F00D);

    for (int i = 0; i < 8; i++) begin
      fetch(0, vt[i].addr, vt[i].inst, vt[i].err, 1'b0, 0, 32'h0, $sformatf("vec%0d", i));
    end

    // Backpressure: response held 5 cycles while a competing request is offered.
    req_valid[0]  = 1'b1;
    req_addr[0]   = BASE + 32'd20;
    resp_ready[0] = 1'b0;
    step;
    req_addr[0] = BASE;
    n = 1;
    while (resp_valid[0] !== 1'b1 && n < 12) begin
      step;
      n++;
    end
    chk("hold/lat", 32'(n), 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk("hold/valid", 32'(resp_valid[0]), 32'd1);
      chk("hold/inst", resp_inst[0], 32'h1234_5678);
      chk("hold/err", 32'(resp_err[0]), 32'd0);
      chk("hold/req_ready", 32'(req_ready[0]), 32'd0);
      step;
    end
    req_valid[0]  = 1'b0;
    resp_ready[0] = 1'b1;
    step;
    for (int i = 0; i < 3; i++) begin
      chk("hold/no_stray", 32'(resp_valid[0]), 32'd0);
      step;
    end

    // Read-before-write on the accept edge, then the new word on refetch.
    fetch(0, BASE + 32'd4, 32'h0000_0013, 1'b0, 1'b1, 1, 32'hDEAD_BEEF, "rbw_old");
    fetch(0, BASE + 32'd4, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 32'h0, "rbw_new");

    // Reset in the middle of WAIT.
    req_valid[0] = 1'b1;
    req_addr[0]  = BASE;
    step;
    req_valid[0] = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_wait/req_ready", 32'(req_ready[0]), 32'd1);
    chk("rst_wait/resp_valid", 32'(resp_valid[0]), 32'd0);
    chk("rst_wait/resp_inst", resp_inst[0], 32'h0);
    step;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_wait/no_valid", 32'(resp_valid[0]), 32'd0);
      step;
    end
    fetch(0, BASE, 32'h0010_0093, 1'b0, 1'b0, 0, 32'h0, "post_rst");

    // Reset while a response is being held in RESP.
    req_valid[0]  = 1'b1;
    req_addr[0]   = BASE + 32'd2;
    resp_ready[0] = 1'b0;
    step;
    req_valid[0] = 1'b0;
    n = 1;
    while (resp_valid[0] !== 1'b1 && n < 12) begin
      step;
      n++;
    end
    chk("rst_resp/err_before", 32'(resp_err[0]), 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_resp/resp_valid", 32'(resp_valid[0]), 32'd0);
    chk("rst_resp/resp_err", 32'(resp_err[0]), 32'd0);
    step;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_resp/no_valid", 32'(resp_valid[0]), 32'd0);
      step;
    end
    resp_ready[0] = 1'b1;

    // Back-to-back random fetches on the LATENCY=1 and LATENCY=7 builds.
    for (int k = 1; k < NI; k++) begin
      for (int i = 0; i < 16; i++) load(k, i, $urandom);
      for (int t = 0; t < 100; t++) begin
        r   = int'($urandom_range(0, 9));
        idx = int'($urandom_range(0, 15));
        if (r < 7)       addr = BASE + 32'(4*idx);
        else if (r == 7) addr = BASE + 32'(4*idx) + 32'($urandom_range(1, 3));
        else if (r == 8) addr = BASE + 32'(4*DEPTH) + 32'(4*idx);
        else             addr = BASE - 32'(4*(idx + 1));
        off = addr - BASE;
        ee  = (addr[1:0] != 2'b00) || (off >= 32'(4*DEPTH));
        ei  = ee ? EBRK : model[k][off[11:2]];
        dold = ($urandom_range(0, 3) == 0);
        li   = int'($urandom_range(0, 15));
        ldv  = $urandom;
        fetch(k, addr, ei, ee, dold, li, ldv, $sformatf("rnd_l%0d_%0d", lat_of(k), t));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
